unpack: RTL

UNPACK -- requirements
Module: unpack

---
 rtl/unpack.sv | 123 ++++++++++++
 1 files changed

// File: rtl/unpack.sv
// Serial packet unpacker: hunts for a sync word, then rebuilds MSB-first payload bytes into a small output FIFO.
// Optional macro UNPACK_SYNC_TOLERANCE_EN: accept the sync word with up to one bit error.
module unpack #(
  parameter int                       SIZE_BIT_PACK = 1976,
  parameter int                       SIZE_PREAMBLE = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE      = 32'h1ACFFC1D,
  parameter int                       FIFO_DEPTH    = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_data,
  input  logic       i_valid,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_sync,
  output logic       o_pack_done,
  output logic       o_overflow
);
  localparam int PAY_BITS = SIZE_BIT_PACK - SIZE_PREAMBLE;
  localparam int CW       = (PAY_BITS > 1) ? $clog2(PAY_BITS) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t                   state, state_n;
  // Only the newest SIZE_PREAMBLE-1 bits are kept; with i_data they form the full window.
  logic [SIZE_PREAMBLE-2:0] hist, hist_n;
  logic [SIZE_PREAMBLE-1:0] win_shift;
  logic [CW-1:0]            cnt, cnt_n;
  logic [6:0]               sr, sr_n;
  logic [7:0]               byte_shift, push_byte;
  logic                     match, last, push, sync_n, done_n;

  logic [7:0]               mem [FIFO_DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr;
  logic                     empty, full, pop, wr_en, ovf_set;

  assign win_shift  = {hist, i_data};
  assign byte_shift = {sr, i_data};
  assign last       = (cnt == CW'(PAY_BITS - 1));
  // A short final byte is left-aligned so its first bit still lands in bit 7.
  assign push_byte  = byte_shift << (3'd7 - cnt[2:0]);

`ifdef UNPACK_SYNC_TOLERANCE_EN
  logic [SIZE_PREAMBLE-1:0] diff;
  assign diff  = win_shift ^ PREAMBLE;
  assign match = ((diff & (diff - 1'b1)) == '0);
`else
  assign match = (win_shift == PREAMBLE);
`endif

  always_comb begin
    state_n = state;
    hist_n  = hist;
    cnt_n   = cnt;
    sr_n    = sr;
    push    = 1'b0;
    sync_n  = 1'b0;
    done_n  = 1'b0;
    if (i_valid) begin
      case (state)
        HUNT: begin
          hist_n = win_shift[SIZE_PREAMBLE-2:0];
          if (match) begin
            state_n = PAYLOAD;
            cnt_n   = '0;
            sync_n  = 1'b1;
          end
        end
        PAYLOAD: begin
          sr_n  = byte_shift[6:0];
          cnt_n = cnt + 1'b1;
          push  = (cnt[2:0] == 3'd7) || last;
          if (last) begin
            state_n = HUNT;
            hist_n  = '0;
            cnt_n   = '0;
            done_n  = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && i_ready;
  // When full, a same-cycle pop frees the slot being written, so the push still lands.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign o_valid = !empty;
  assign o_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_byte;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= HUNT;
      hist        <= '0;
      cnt         <= '0;
      sr          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_sync      <= 1'b0;
      o_pack_done <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state       <= state_n;
      hist        <= hist_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      o_sync      <= sync_n;
      o_pack_done <= done_n;
      if (wr_en)   wr_ptr     <= wr_ptr + 1'b1;
      if (pop)     rd_ptr     <= rd_ptr + 1'b1;
      if (ovf_set) o_overflow <= 1'b1;
    end
  end
endmodule
